hazard_stall_ctrl: RTL

- Central hazard and stall controller for the 5-stage pipelined MIPS core.
- Watches register fields from the ID, EX and MEM stages, plus the data-memory handshake.
- Drives the PC hold, IF/ID hold and flush, ID/EX bubble, EX/MEM hold and MEM/WB bubble controls.
- Sequences multi-cycle stalls (branch-after-load, slow data memory) with a small FSM, replacing the ad-hoc hold logic in the decode stage.

---
 rtl/mips_pkg.sv | 13 +
 rtl/hazard_match.sv | 15 +
 rtl/hazard_stall_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline-control types and constants for the MIPS core
package mips_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP      = 32'h0000_0000;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - true when the ID instruction sources a given destination register
module hazard_match
  import mips_pkg::*;
(
  input  logic [4:0] i_dst,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  input  logic       i_uses_rt,
  output logic       o_match
);

  assign o_match = (i_dst != REG_ZERO) &&
                   ((i_dst == i_rs) || (i_uses_rt && (i_dst == i_rt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard/stall sequencer; HAZARD_PERF_CNT_EN adds perf counters
module hazard_stall_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             branch_taken,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [4:0]       ex_wreg,
  input  logic             mem_memread,
  input  logic [4:0]       mem_wreg,
  input  logic             mem_req,
  input  logic             mem_ready,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] memwait_cycles,
`endif
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic             mem_err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT = CW'(MEM_TIMEOUT);

  hz_state_t     r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_err, w_err_set;
  logic          w_freeze, w_stall, w_flush;
  logic          w_m_exld, w_m_exalu, w_m_memld;
  logic          w_freeze_req, w_hazard;

  // Destinations are pre-qualified by instruction type so each match means one rule.
  hazard_match u_match_exld (
    .i_dst(ex_memread ? ex_wreg : REG_ZERO), .i_rs(id_rs), .i_rt(id_rt),
    .i_uses_rt(id_uses_rt), .o_match(w_m_exld)
  );
  hazard_match u_match_exalu (
    .i_dst((ex_regwrite && !ex_memread) ? ex_wreg : REG_ZERO), .i_rs(id_rs), .i_rt(id_rt),
    .i_uses_rt(id_uses_rt), .o_match(w_m_exalu)
  );
  hazard_match u_match_memld (
    .i_dst(mem_memread ? mem_wreg : REG_ZERO), .i_rs(id_rs), .i_rt(id_rt),
    .i_uses_rt(id_uses_rt), .o_match(w_m_memld)
  );

  assign w_freeze_req = mem_req && !mem_ready;
  assign w_hazard     = w_m_exld || (id_branch && (w_m_exalu || w_m_memld));

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_err_set = 1'b0;
    w_freeze  = 1'b0;
    w_stall   = 1'b0;
    w_flush   = 1'b0;
    case (r_state)
      RUN, BR_WAIT: begin
        if (w_freeze_req) begin
          w_freeze  = 1'b1;
          w_next    = MEM_WAIT;
          w_cnt_nxt = CW'(1);
        end else if (r_state == BR_WAIT) begin
          w_stall = 1'b1;
          w_next  = RUN;
        end else if (w_hazard) begin
          w_stall = 1'b1;
          if (id_branch && w_m_exld) w_next = BR_WAIT;
        end else begin
          w_flush = id_branch && branch_taken;
        end
      end
      MEM_WAIT: begin
        w_freeze = 1'b1;
        if (mem_ready) begin
          w_next    = RUN;
          w_cnt_nxt = '0;
        end else if (r_cnt + 1'b1 >= TIMEOUT) begin
          w_err_set = 1'b1;
          w_next    = RUN;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_next    = RUN;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Gating by rst_n drops every hold the instant reset asserts, without waiting for an edge.
  assign pc_hold      = rst_n && (w_freeze || w_stall);
  assign ifid_hold    = rst_n && (w_freeze || w_stall);
  assign ifid_flush   = rst_n && w_flush;
  assign idex_bubble  = rst_n && w_stall;
  assign exmem_hold   = rst_n && w_freeze;
  assign memwb_bubble = rst_n && w_freeze;
  assign mem_err      = rst_n && r_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles, r_flush_count, r_memwait_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles   <= '0;
      r_flush_count    <= '0;
      r_memwait_cycles <= '0;
    end else begin
      if (w_stall  && (r_stall_cycles   != '1)) r_stall_cycles   <= r_stall_cycles + 1'b1;
      if (w_flush  && (r_flush_count    != '1)) r_flush_count    <= r_flush_count + 1'b1;
      if (w_freeze && (r_memwait_cycles != '1)) r_memwait_cycles <= r_memwait_cycles + 1'b1;
    end
  end

  assign stall_cycles   = r_stall_cycles;
  assign flush_count    = r_flush_count;
  assign memwait_cycles = r_memwait_cycles;
`endif

endmodule
